// File: rtl/dcache_line_server.sv
// dcache_line_server: memory-side responder for dCache line misses and evicts.
// An accepted request optionally writes back an evicted line word by word.
// It then reads the missing line word by word over a req/ack port.
// The assembled line is returned with a single-cycle fillValid pulse.
module dcache_line_server #(
  parameter int WORDS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cacheMiss,
  input  logic [31:0]          missAddr,
  input  logic                 cacheEvictValid,
  input  logic [31:0]          evictAddr,
  input  logic [32*WORDS-1:0]  evictBlk,
  output logic [32*WORDS-1:0]  fillBlk,
  output logic                 fillValid,
  output logic                 busy,
  output logic                 memReq,
  output logic                 memWe,
  output logic [31:0]          memAddr,
  output logic [31:0]          memWrData,
  input  logic                 memAck,
  input  logic [31:0]          memRdData
);

  // Word index width, byte offset of a line, and line-address width.
  localparam int CW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int OFF = CW + 2;
  localparam int LW  = 32 - OFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2,
    FILL = 2'd3
  } state_t;

  state_t         state;
  state_t         stateNext;
  logic [CW-1:0]  wordCnt;
  logic           missPending;
  logic [LW-1:0]  missLine;
  logic [LW-1:0]  evictLine;
  logic [31:0]    evictMem [WORDS];

  logic           accept;
  logic           beat;
  logic           lastWord;
  logic           unusedAddrBits;

  // A request is taken only while idle; everything else ignores the request lines.
  assign accept   = (state == IDLE) && (cacheMiss || cacheEvictValid);
  // One word completes whenever the memory acknowledges an outstanding transfer.
  assign beat     = ((state == WB) || (state == RD)) && memAck;
  assign lastWord = (wordCnt == CW'(WORDS - 1));

  // Byte offsets inside a line never reach the memory port.
  assign unusedAddrBits = ^{missAddr[OFF-1:0], evictAddr[OFF-1:0]};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Word counter and the remembered "a read follows the writeback" flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wordCnt     <= '0;
      missPending <= 1'b0;
    end else if (accept) begin
      wordCnt     <= '0;
      missPending <= cacheMiss;
    end else if (beat) begin
      wordCnt     <= lastWord ? '0 : wordCnt + CW'(1);
    end
  end

  // Capture line addresses and the evicted data when a request is accepted.
  always_ff @(posedge clk) begin
    // NOTE: these are pure data holding registers, written before any use
    // on every acceptance, so they carry no reset; a reset simply discards them.
    if (accept) begin
      missLine  <= missAddr[31:OFF];
      evictLine <= evictAddr[31:OFF];
      for (int i = 0; i < WORDS; i++) begin
        evictMem[i] <= evictBlk[32*i +: 32];
      end
    end
  end

  // Assemble the fetched line; it holds after FILL until the next read overwrites it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fillBlk <= '0;
    end else if ((state == RD) && memAck) begin
      for (int i = 0; i < WORDS; i++) begin
        if (wordCnt == CW'(i)) begin
          fillBlk[32*i +: 32] <= memRdData;
        end
      end
    end
  end

  // Next-state and output decode; outputs depend only on registered state.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    stateNext = state;
    memReq    = 1'b0;
    memWe     = 1'b0;
    memAddr   = '0;
    memWrData = '0;
    busy      = (state != IDLE);
    fillValid = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          stateNext = cacheEvictValid ? WB : RD;
        end
      end

      WB: begin
        memReq    = 1'b1;
        memWe     = 1'b1;
        memAddr   = {evictLine, wordCnt, 2'b00};
        memWrData = evictMem[wordCnt];
        if (beat && lastWord) begin
          stateNext = missPending ? RD : IDLE;
        end
      end

      RD: begin
        memReq  = 1'b1;
        memAddr = {missLine, wordCnt, 2'b00};
        if (beat && lastWord) begin
          stateNext = FILL;
        end
      end

      FILL: begin
        fillValid = 1'b1;
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_line_server.sv
// tb_dcache_line_server: drives line requests, plays the memory side with
// programmable wait states, and checks transfers, fill data and timing
// against a transaction-level reference model.
module tb_dcache_line_server;

  localparam int WORDS = 16;
  localparam int LB    = 32 * WORDS;
  localparam int MAXC  = 400;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           cacheMiss = 1'b0;
  logic [31:0]    missAddr = '0;
  logic           cacheEvictValid = 1'b0;
  logic [31:0]    evictAddr = '0;
  logic [LB-1:0]  evictBlk = '0;
  logic [LB-1:0]  fillBlk;
  logic           fillValid;
  logic           busy;
  logic           memReq;
  logic           memWe;
  logic [31:0]    memAddr;
  logic [31:0]    memWrData;
  logic           memAck = 1'b0;
  logic [31:0]    memRdData = '0;

  dcache_line_server #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .cacheMiss(cacheMiss), .missAddr(missAddr),
    .cacheEvictValid(cacheEvictValid), .evictAddr(evictAddr), .evictBlk(evictBlk),
    .fillBlk(fillBlk), .fillValid(fillValid), .busy(busy),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWrData(memWrData),
    .memAck(memAck), .memRdData(memRdData)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } txn_t;

  int            total = 0;
  int            bad   = 0;
  txn_t          gotQ[$];
  txn_t          expQ[$];
  logic [LB-1:0] expFill;
  logic [LB-1:0] lastFill = '0;
  int            rdMode = 0;
  logic [31:0]   rdBase = '0;

  int            fillCycle, fillCount, busyLowCycle, stallViol, stallCount;
  int            firstReadCyc, lastWriteAckCyc;
  bit            timedOut, resetHit;
  logic [LB-1:0] fillLine;
  logic [67:0]   snapCtl;
  logic [LB-1:0] snapFill;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory contents seen by reads: a fixed function of the word address.
  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (rdMode == 0) return rdBase + {28'd0, a[5:2]};
    return rdBase ^ (a * 32'h9E37_79B1);
  endfunction

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] v;
    for (int i = 0; i < WORDS; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Reference model: the ordered word transactions and the fill line a request must produce.
  task automatic build_exp(input bit miss, input bit evict, input logic [31:0] mA,
                           input logic [31:0] eA, input logic [LB-1:0] eB);
    txn_t t;
    expQ.delete();
    expFill = lastFill;
    if (evict) begin
      for (int i = 0; i < WORDS; i++) begin
        t.we = 1'b1; t.addr = (eA & 32'hFFFF_FFC0) + 32'(4 * i);
        t.data = eB[32*i +: 32]; t.cyc = 0;
        expQ.push_back(t);
      end
    end
    if (miss) begin
      for (int i = 0; i < WORDS; i++) begin
        t.we = 1'b0; t.addr = (mA & 32'hFFFF_FFC0) + 32'(4 * i);
        t.data = rd_word(t.addr); t.cyc = 0;
        expQ.push_back(t);
        expFill[32*i +: 32] = t.data;
      end
    end
  endtask

  // Index of the first differing transaction, or -1 when both lists agree.
  function automatic int txn_diff();
    int n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      if (gotQ[i].we !== expQ[i].we || gotQ[i].addr !== expQ[i].addr ||
          gotQ[i].data !== expQ[i].data) return i;
    end
    if (gotQ.size() != expQ.size()) return n;
    return -1;
  endfunction

  // Issue one request and act as the memory until the block returns to idle.
  task automatic run_req(input bit miss, input bit evict, input logic [31:0] mA,
                         input logic [31:0] eA, input logic [LB-1:0] eB,
                         input int ackPeriod, input bit holdMiss,
                         input logic [31:0] nextMiss, input bit disturb,
                         input int rstAtWrite);
    int          waitCnt = 0;
    int          writesAcked = 0;
    bit          pReq = 0, pAck = 0, pWe = 0, ack, finished = 0;
    logic [31:0] pAddr = '0, pData = '0;
    txn_t        t;
    gotQ.delete();
    fillCycle = -1; fillCount = 0; busyLowCycle = -1; stallViol = 0; stallCount = 0;
    firstReadCyc = -1; lastWriteAckCyc = -1; timedOut = 0; resetHit = 0; fillLine = '0;
    cacheMiss = miss; cacheEvictValid = evict; missAddr = mA; evictAddr = eA;
    evictBlk = eB; memAck = 1'b0;
    tick();
    cacheEvictValid = 1'b0;
    for (int k = 1; k <= MAXC; k++) begin
      if (disturb) begin
        missAddr = $urandom; evictAddr = $urandom; evictBlk = rand_line();
        cacheEvictValid = (k >= 3 && k <= 8);
      end
      if (busy !== 1'b1) begin
        busyLowCycle = k; finished = 1; break;
      end
      if (fillValid === 1'b1) begin
        fillCount++;
        if (fillCycle < 0) begin fillCycle = k; fillLine = fillBlk; end
        if (holdMiss) missAddr = nextMiss; else cacheMiss = 1'b0;
      end
      ack = 0;
      if (memReq === 1'b1) begin
        if (pReq && !pAck && (memWe !== pWe || memAddr !== pAddr || memWrData !== pData))
          stallViol++;
        if (rstAtWrite >= 0 && memWe === 1'b1 && writesAcked == rstAtWrite) begin
          #2 rst = 1'b0;
          #1;
          snapCtl  = {fillValid, busy, memReq, memWe, memAddr, memWrData};
          snapFill = fillBlk;
          resetHit = 1; finished = 1;
          break;
        end
        if (ackPeriod == 0) ack = ($urandom_range(0, 2) != 0);
        else ack = (waitCnt == ackPeriod - 1);
        if (ack) waitCnt = 0;
        else begin waitCnt++; stallCount++; end
        if (memWe !== 1'b1 && firstReadCyc < 0) firstReadCyc = k;
        if (ack) begin
          t.we = memWe; t.addr = memAddr;
          t.data = memWe ? memWrData : rd_word(memAddr); t.cyc = k;
          gotQ.push_back(t);
          if (memWe) begin writesAcked++; lastWriteAckCyc = k; end
        end
        memRdData = (ack && !memWe) ? rd_word(memAddr) : $urandom;
      end else begin
        memRdData = $urandom;
      end
      memAck = ack;
      pReq = memReq; pAck = ack; pWe = memWe; pAddr = memAddr; pData = memWrData;
      tick();
    end
    memAck = 1'b0;
    if (!finished) timedOut = 1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    total++; if ({fillValid, busy, memReq, memWe} !== 4'b0) begin bad++;
      $display("FAIL reset_ctl got=%b exp=0000", {fillValid, busy, memReq, memWe}); end
    total++; if ({memAddr, memWrData} !== 64'd0) begin bad++;
      $display("FAIL reset_bus got=%h exp=0", {memAddr, memWrData}); end
    total++; if (fillBlk !== '0) begin bad++;
      $display("FAIL reset_fill got=%h exp=0", fillBlk); end
    rst = 1'b1;
    repeat (2) tick();
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_clean_miss();
    rdMode = 0; rdBase = 32'hA000_0000;
    build_exp(1, 0, 32'h0000_1234, '0, '0);
    run_req(1, 0, 32'h0000_1234, '0, '0, 1, 0, '0, 0, -1);
    total++; if (timedOut) begin bad++; $display("FAIL clean_timeout got=1 exp=0"); end
    total++; if (txn_diff() !== -1) begin bad++;
      $display("FAIL clean_txn idx=%0d got=%h/%h exp=%h/%h n=%0d/%0d", txn_diff(),
               gotQ[txn_diff()].addr, gotQ[txn_diff()].data, expQ[txn_diff()].addr,
               expQ[txn_diff()].data, gotQ.size(), expQ.size()); end
    total++; if (gotQ[0].addr !== 32'h1200 || gotQ[15].addr !== 32'h123C) begin bad++;
      $display("FAIL clean_addr_range got=%h..%h exp=1200..123c", gotQ[0].addr, gotQ[15].addr); end
    total++; if (fillCount !== 1 || fillCycle !== 17) begin bad++;
      $display("FAIL clean_fill_timing got=%0d@%0d exp=1@17", fillCount, fillCycle); end
    total++; if (fillLine !== expFill) begin bad++;
      $display("FAIL clean_fill_data got=%h exp=%h", fillLine, expFill); end
    total++; if (busyLowCycle !== 18) begin bad++;
      $display("FAIL clean_busy_fall got=%0d exp=18", busyLowCycle); end
    lastFill = expFill;
  endtask

  task automatic test_evict_only();
    logic [LB-1:0] eB = rand_line();
    logic [31:0]   eA = $urandom;
    build_exp(0, 1, '0, eA, eB);
    run_req(0, 1, '0, eA, eB, 1, 0, '0, 0, -1);
    total++; if (txn_diff() !== -1) begin bad++;
      $display("FAIL evict_txn idx=%0d n=%0d/%0d", txn_diff(), gotQ.size(), expQ.size()); end
    total++; if (fillCount !== 0 || firstReadCyc !== -1) begin bad++;
      $display("FAIL evict_no_fill got=%0d,%0d exp=0,-1", fillCount, firstReadCyc); end
    total++; if (busyLowCycle !== 17) begin bad++;
      $display("FAIL evict_busy_fall got=%0d exp=17", busyLowCycle); end
    total++; if (fillBlk !== lastFill) begin bad++;
      $display("FAIL evict_fill_hold got=%h exp=%h", fillBlk, lastFill); end
  endtask

  task automatic test_dirty_miss();
    logic [LB-1:0] eB;
    logic [31:0]   mA = $urandom;
    for (int i = 0; i < WORDS; i++) eB[32*i +: 32] = 32'(i);
    rdMode = 1; rdBase = $urandom;
    build_exp(1, 1, mA, 32'h0000_8040, eB);
    run_req(1, 1, mA, 32'h0000_8040, eB, 1, 0, '0, 0, -1);
    total++; if (txn_diff() !== -1) begin bad++;
      $display("FAIL dirty_txn idx=%0d n=%0d/%0d", txn_diff(), gotQ.size(), expQ.size()); end
    total++; if (lastWriteAckCyc !== 16 || firstReadCyc !== 17) begin bad++;
      $display("FAIL dirty_order got=%0d,%0d exp=16,17", lastWriteAckCyc, firstReadCyc); end
    total++; if (fillCycle !== 33 || busyLowCycle !== 34) begin bad++;
      $display("FAIL dirty_timing got=%0d,%0d exp=33,34", fillCycle, busyLowCycle); end
    total++; if (fillLine !== expFill) begin bad++;
      $display("FAIL dirty_fill_data got=%h exp=%h", fillLine, expFill); end
    lastFill = expFill;
  endtask

  task automatic test_wait_states();
    logic [31:0] mA = $urandom;
    rdMode = 1; rdBase = $urandom;
    build_exp(1, 0, mA, '0, '0);
    run_req(1, 0, mA, '0, '0, 3, 0, '0, 0, -1);
    total++; if (stallViol !== 0 || stallCount !== 32) begin bad++;
      $display("FAIL wait_stable got=%0d,%0d exp=0,32", stallViol, stallCount); end
    total++; if (fillCycle !== 49 || busyLowCycle !== 50) begin bad++;
      $display("FAIL wait_timing got=%0d,%0d exp=49,50", fillCycle, busyLowCycle); end
    total++; if (txn_diff() !== -1 || fillLine !== expFill) begin bad++;
      $display("FAIL wait_data idx=%0d got=%h exp=%h", txn_diff(), fillLine, expFill); end
    lastFill = expFill;
  endtask

  task automatic test_busy_request();
    logic [31:0]   mA = $urandom;
    logic [31:0]   eA = $urandom;
    logic [LB-1:0] eB = rand_line();
    rdMode = 1; rdBase = $urandom;
    build_exp(1, 1, mA, eA, eB);
    run_req(1, 1, mA, eA, eB, 2, 0, '0, 1, -1);
    total++; if (txn_diff() !== -1) begin bad++;
      $display("FAIL busy_req_txn idx=%0d got=%h exp=%h", txn_diff(),
               gotQ[txn_diff()].addr, expQ[txn_diff()].addr); end
    total++; if (fillLine !== expFill || stallViol !== 0) begin bad++;
      $display("FAIL busy_req_fill viol=%0d got=%h exp=%h", stallViol, fillLine, expFill); end
    total++; if (fillCycle !== 2 * WORDS + stallCount + 1) begin bad++;
      $display("FAIL busy_req_timing got=%0d exp=%0d", fillCycle, 2 * WORDS + stallCount + 1); end
    repeat (2) tick();
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL busy_req_no_restart got=%b exp=0", busy); end
    lastFill = expFill;
  endtask

  task automatic test_back_to_back();
    logic [31:0] mA1 = $urandom;
    logic [31:0] mA2 = $urandom;
    rdMode = 1; rdBase = $urandom;
    build_exp(1, 0, mA1, '0, '0);
    run_req(1, 0, mA1, '0, '0, 1, 1, mA2, 0, -1);
    total++; if (txn_diff() !== -1 || fillCycle !== 17 || busyLowCycle !== 18) begin bad++;
      $display("FAIL b2b_first idx=%0d got=%0d,%0d exp=17,18", txn_diff(), fillCycle, busyLowCycle); end
    lastFill = expFill;
    build_exp(1, 0, mA2, '0, '0);
    run_req(1, 0, mA2, '0, '0, 1, 0, '0, 0, -1);
    total++; if (fillCycle !== 17 || busyLowCycle !== 18) begin bad++;
      $display("FAIL b2b_second_timing got=%0d,%0d exp=17,18", fillCycle, busyLowCycle); end
    total++; if (txn_diff() !== -1 || fillLine !== expFill) begin bad++;
      $display("FAIL b2b_second_data idx=%0d got=%h exp=%h", txn_diff(), fillLine, expFill); end
    lastFill = expFill;
  endtask

  task automatic test_reset_mid_wb();
    logic [31:0] mA = $urandom;
    rdMode = 1; rdBase = $urandom;
    run_req(1, 1, mA, $urandom, rand_line(), 1, 0, '0, 0, 5);
    total++; if (!resetHit || gotQ.size() !== 5) begin bad++;
      $display("FAIL rst_wb_reach got=%0d,%0d exp=1,5", resetHit, gotQ.size()); end
    total++; if (snapCtl !== 68'd0) begin bad++;
      $display("FAIL rst_wb_outputs got=%h exp=0", snapCtl); end
    total++; if (snapFill !== '0) begin bad++;
      $display("FAIL rst_wb_fill got=%h exp=0", snapFill); end
    cacheMiss = 1'b0; cacheEvictValid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL rst_wb_idle got=%b exp=0", busy); end
    lastFill = '0;
    mA = $urandom;
    build_exp(1, 0, mA, '0, '0);
    run_req(1, 0, mA, '0, '0, 1, 0, '0, 0, -1);
    total++; if (txn_diff() !== -1 || gotQ[0].addr !== (mA & 32'hFFFF_FFC0)) begin bad++;
      $display("FAIL rst_wb_recover_txn idx=%0d got=%h exp=%h", txn_diff(), gotQ[0].addr,
               mA & 32'hFFFF_FFC0); end
    total++; if (fillCycle !== 17 || fillLine !== expFill) begin bad++;
      $display("FAIL rst_wb_recover_fill at=%0d got=%h exp=%h", fillCycle, fillLine, expFill); end
    lastFill = expFill;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int            kind = $urandom_range(1, 3);
      bit            m = (kind != 2);
      bit            e = (kind != 1);
      logic [31:0]   mA = $urandom;
      logic [31:0]   eA = $urandom;
      logic [LB-1:0] eB = rand_line();
      int            expLow;
      rdMode = 1; rdBase = $urandom;
      build_exp(m, e, mA, eA, eB);
      run_req(m, e, mA, eA, eB, 0, 0, '0, 0, -1);
      expLow = (m ? WORDS : 0) + (e ? WORDS : 0) + stallCount + (m ? 2 : 1);
      total++; if (timedOut || txn_diff() !== -1) begin bad++;
        $display("FAIL rand%0d_txn to=%0d idx=%0d n=%0d/%0d", it, timedOut, txn_diff(),
                 gotQ.size(), expQ.size()); end
      total++; if (fillCount !== (m ? 1 : 0) || busyLowCycle !== expLow) begin bad++;
        $display("FAIL rand%0d_timing got=%0d,%0d exp=%0d,%0d", it, fillCount, busyLowCycle,
                 m ? 1 : 0, expLow); end
      total++; if (fillBlk !== expFill) begin bad++;
        $display("FAIL rand%0d_fill got=%h exp=%h", it, fillBlk, expFill); end
      lastFill = expFill;
    end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_evict_only();
    test_dirty_miss();
    test_wait_states();
    test_busy_request();
    test_back_to_back();
    test_reset_mid_wb();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
